i2c_slave_regs: RTL

- I2C target (responder) with an internal byte register bank.
- Sits on the same SDA/SCL bus as our I2C master bridge and answers its START/address/data/STOP sequences.
- Lets master-issued writes and reads reach on-chip registers.
- A host-side port gives local logic direct access to the same register bank.

---
 rtl/i2c_slave_regs.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target with a 2^AW-byte register bank; pointer byte then data, auto-incrementing.
// Optional 3-sample majority glitch filter on SCL/SDA when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         AW          = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic [3:0]    state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8,
        S_RWAIT     = 4'd9
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_f, sda_f, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_c, stop_c;

    state_t         st;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic [7:0]     rx_byte;
    logic [AW-1:0]  ptr;
    logic [AW-1:0]  ptr_next;
    logic           drive;
    logic           ack_on;
    logic           rw;
    logic [7:0]     regs [1 << AW];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_win, sda_win;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_win <= '1;
            sda_win <= '1;
        end else begin
            scl_win <= {scl_win[1:0], scl_s};
            sda_win <= {sda_win[1:0], sda_s};
        end
    end

    // A single-clock pulse occupies only one window slot, so the majority never flips.
    assign scl_f = (scl_win[0] & scl_win[1]) | (scl_win[1] & scl_win[2]) | (scl_win[0] & scl_win[2]);
    assign sda_f = (sda_win[0] & sda_win[1]) | (sda_win[1] & sda_win[2]) | (sda_win[0] & sda_win[2]);
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

    assign rx_byte    = {shift[6:0], sda_f};
    assign ptr_next   = ptr + PTR_ONE;
    assign host_rdata = regs[host_addr];
    assign state      = st;
    // Gated by reset so the bus is freed in the same cycle reset is asserted.
    assign sda_oe     = drive & reset_n;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would make later statements see updated values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st       <= S_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            drive    <= 1'b0;
            ack_on   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            // NOTE: the bank must read back as zero after reset, so it is cleared here;
            // this rules out mapping it onto a RAM macro without reset.
            for (int i = 0; i < (1 << AW); i++) regs[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            // Host write first: a same-cycle I2C write below overrides it.
            if (host_we) regs[host_addr] <= host_wdata;

            if (start_c) begin
                st      <= S_ADDR;
                bit_cnt <= '0;
                drive   <= 1'b0;
                ack_on  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_c) begin
                st     <= S_IDLE;
                drive  <= 1'b0;
                ack_on <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (st)
                    S_ADDR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                st     <= S_ADDR_ACK;
                                busy   <= 1'b1;
                                rw     <= rx_byte[0];
                                ack_on <= 1'b0;
                            end else begin
                                st <= S_IDLE;
                            end
                        end
                    end

                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            drive  <= 1'b1;
                            ack_on <= 1'b1;
                        end else begin
                            drive   <= 1'b0;
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            if (st == S_ADDR_ACK && rw) begin
                                st    <= S_RDATA;
                                shift <= regs[ptr];
                                drive <= ~regs[ptr][7];
                            end else if (st == S_ADDR_ACK) begin
                                st <= S_PTR;
                            end else begin
                                st <= S_WDATA;
                            end
                        end
                    end

                    S_PTR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr    <= rx_byte[AW-1:0];
                            st     <= S_PTR_ACK;
                            ack_on <= 1'b0;
                        end
                    end

                    S_WDATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            regs[ptr] <= rx_byte;
                            wr_pulse  <= 1'b1;
                            wr_addr   <= ptr;
                            ptr       <= ptr_next;
                            st        <= S_WDATA_ACK;
                            ack_on    <= 1'b0;
                        end
                    end

                    // bit_cnt counts master samples; 0 on a fall means the first bit is still pending.
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                drive <= ~shift[7];
                            end else if (bit_cnt == 4'd8) begin
                                drive <= 1'b0;
                                st    <= S_RACK;
                            end else begin
                                shift <= {shift[6:0], 1'b0};
                                drive <= ~shift[6];
                            end
                        end
                    end

                    S_RACK: if (scl_rise) begin
                        if (!sda_f) begin
                            ptr     <= ptr_next;
                            shift   <= regs[ptr_next];
                            bit_cnt <= '0;
                            st      <= S_RDATA;
                        end else begin
                            st <= S_RWAIT;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule
